cpu_step_ctrl: RTL and testbench
================================

Name: cpu_step_ctrl

Overview:
- Sits directly downstream of the slow-clock divider in the multi-cycle MIPS CPU board top.
- Synchronises the divided clock level and turns each of its rising edges into a one-cycle CPU clock-enable pulse.
- Also provides a debounced single-step push-button mode and a halt latch, so the CPU runs free, steps manually or stops cleanly.
- Drives a retired-cycle counter for the display logic.

Parameters:
- DEB_CYCLES, 1000000, CLK_in cycles a button level must stay stable before it is accepted; must be ≥2.
- CNT_W, 32, width of cycle_count.

Ports:
- CLK_in  input  1  board clock; all logic on its rising edge.
- RST_n  input  1  reset, synchronous, active-low.
- slow_clk  input  1  divided clock level from the divider; treated as asynchronous.
- mode_run  input  1  slide switch: 1 = free-run, 0 = single-step; asynchronous.
- btn_step  input  1  raw step push-button, active-high, bouncy; asynchronous.
- halt_i  input  1  CPU halt request; synchronous to CLK_in.
- cpu_ce  output  1  registered one-cycle clock-enable pulse to the CPU.
- state_o  output  2  FSM state: 0 PAUSE, 1 RUN, 2 HALT.
- cycle_count  output  CNT_W  number of cpu_ce pulses issued since reset.

Behaviour:
- Reset: RST_n low at a CLK_in edge clears everything on that edge.
  - Cleared: all synchroniser flops, debounce counter, debounced level, cpu_ce=0, state_o=0 (PAUSE), cycle_count=0.
  - A reset mid-pulse drops cpu_ce in the same edge.
- Synchronisers:
  - slow_clk, mode_run and btn_step each pass through 2 flops (s1, s2).
  - slow_clk has a third flop s3; tick = s2 & ~s3.
  - cpu_ce rises on the 4th CLK_in edge counting the first edge that samples slow_clk=1 as edge 1.
  - A falling slow_clk edge produces no tick.
- Debounce:
  - btn_deb holds the accepted level.
  - While btn_sync equals btn_deb, the counter is held at 0.
  - While they differ, the counter increments each cycle.
  - When the counter equals DEB_CYCLES-1 and they still differ: btn_deb <= btn_sync and the counter clears.
  - Any glitch back to btn_deb before then clears the counter.
  - press = btn_deb rising, registered as a one-cycle strobe.
  - Releases produce no action.
- FSM, evaluated in priority order:
  - HALT: terminal. Only reset leaves it; tick, press and mode changes are ignored.
  - Any state: halt_i=1 → HALT next edge; cpu_ce forced 0 on that edge, even if a tick or press coincides.
  - PAUSE: mode_sync=1 → RUN. Otherwise a press → cpu_ce=1 for exactly one cycle. Ticks are ignored.
  - RUN: mode_sync=0 → PAUSE. Otherwise a tick → cpu_ce=1 for one cycle. Presses are ignored.
  - Mode change with a coincident tick/press: the transition wins and no pulse is issued that cycle.
- cpu_ce:
  - Registered, never high two consecutive cycles.
  - Minimum spacing is set by slow_clk period or DEB_CYCLES.
- cycle_count:
  - Increments by 1 on every edge where cpu_ce is registered 1, so it is updated alongside the pulse.
  - Saturates at all-ones and does not wrap.
- Output timing: state_o is the registered state; no combinational input-to-output paths.

Test Plan:
- Reset/idle: hold RST_n=0 for 5 cycles with all inputs toggling → cpu_ce=0, state_o=0, cycle_count=0 throughout; after release with mode_run=0, btn_step=0 → no pulses.
- Free-run (DEB_CYCLES=4): mode_run=1, slow_clk toggles every 10 CLK_in cycles for 100 cycles → state_o=1; 5 single-cycle cpu_ce pulses, each on the 4th edge after slow_clk rises; cycle_count=5.
- Step debounce (DEB_CYCLES=4): mode_run=0; btn_step bounces 1-0-1 at 1-cycle spacing, then stays high 20 cycles, then low → exactly one cpu_ce pulse and cycle_count=1. A 2-cycle glitch alone → no pulse.
- Ignored inputs: in RUN, press the button → no extra pulse. In PAUSE, toggle slow_clk 3 times → no pulse, count unchanged.
- Halt priority: in RUN, assert halt_i on the same cycle a tick is due → no cpu_ce, state_o=2. Further ticks, presses and mode changes leave state_o=2 and count unchanged. RST_n=0 → state_o=0, count=0.
- Saturation: preload or force cycle_count to all-ones minus 1 (CNT_W=4: 14), issue 3 ticks in RUN → count reads 15, 15, 15.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// Purpose : turns divided-clock rising edges or debounced step presses into CPU clock-enable pulses, with a halt latch and a retired-cycle counter.
// Latency : cpu_ce rises on the 4th CLK_in edge after slow_clk is first sampled high; a press pulses 2 edges after the debounced level is accepted.
// Backpressure: none; free-running control, pulses are dropped while paused, halted or on a mode transition.
//
// Ports:
//   CLK_in       board clock, all logic on its rising edge
//   RST_n        synchronous active-low reset
//   slow_clk     divided clock level (asynchronous)
//   mode_run     1 = free-run, 0 = single-step (asynchronous)
//   btn_step     raw bouncy step button, active-high (asynchronous)
//   halt_i       CPU halt request, synchronous to CLK_in
//   cpu_ce       registered one-cycle clock-enable pulse
//   state_o      0 PAUSE, 1 RUN, 2 HALT
//   cycle_count  number of cpu_ce pulses since reset, saturating
module cpu_step_ctrl #(
    parameter int DEB_CYCLES = 1000000,
    parameter int CNT_W      = 32
) (
    input  logic             CLK_in,
    input  logic             RST_n,
    input  logic             slow_clk,
    input  logic             mode_run,
    input  logic             btn_step,
    input  logic             halt_i,
    output logic             cpu_ce,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   ce_nxt;

    logic slow_s1, slow_s2, slow_s3;
    logic mode_s1, mode_s2;
    logic btn_s1, btn_s2;
    logic tick;
    logic press;
    logic btn_deb;
    logic [DW-1:0] deb_cnt;

    // Input conditioning: synchronisers, edge detect and debounce.
    // tick and press are both registered strobes so the FSM sees clean
    // single-cycle events.
    always_ff @(posedge CLK_in) begin
        if (!RST_n) begin
            slow_s1 <= 1'b0;
            slow_s2 <= 1'b0;
            slow_s3 <= 1'b0;
            mode_s1 <= 1'b0;
            mode_s2 <= 1'b0;
            btn_s1  <= 1'b0;
            btn_s2  <= 1'b0;
            tick    <= 1'b0;
            press   <= 1'b0;
            btn_deb <= 1'b0;
            deb_cnt <= '0;
        end else begin
            slow_s1 <= slow_clk;
            slow_s2 <= slow_s1;
            slow_s3 <= slow_s2;
            tick    <= slow_s2 & ~slow_s3;
            mode_s1 <= mode_run;
            mode_s2 <= mode_s1;
            btn_s1  <= btn_step;
            btn_s2  <= btn_s1;
            press   <= 1'b0;
            if (btn_s2 == btn_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                // Level has differed for DEB_CYCLES consecutive cycles.
                btn_deb <= btn_s2;
                deb_cnt <= '0;
                press   <= btn_s2;  // only the rising acceptance is a press
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    // Next state and pulse decision. Halt dominates everything, and a
    // mode transition swallows any coincident tick or press.
    always_comb begin
        state_nxt = state;
        ce_nxt    = 1'b0;
        case (state)
            HALT: begin
                state_nxt = HALT;
            end
            PAUSE: begin
                if (halt_i) begin
                    state_nxt = HALT;
                end else if (mode_s2) begin
                    state_nxt = RUN;
                end else if (press) begin
                    ce_nxt = 1'b1;
                end
            end
            RUN: begin
                if (halt_i) begin
                    state_nxt = HALT;
                end else if (!mode_s2) begin
                    state_nxt = PAUSE;
                end else if (tick) begin
                    ce_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = PAUSE;
            end
        endcase
    end

    always_ff @(posedge CLK_in) begin
        if (!RST_n) begin
            state       <= PAUSE;
            cpu_ce      <= 1'b0;
            cycle_count <= '0;
        end else begin
            state  <= state_nxt;
            cpu_ce <= ce_nxt;
            // Counted on the same edge the pulse is registered.
            if (ce_nxt && !(&cycle_count)) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl with DEB_CYCLES=4, CNT_W=4. Directed phases
// followed by a randomized phase; every cycle is compared against a model
// derived from the recorded input history.
module tb_cpu_step_ctrl;

    localparam int DEB     = 4;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int HMAX    = 8192;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          slow;
    logic          mode;
    logic          btn;
    logic          halt;
    logic          ce;
    logic [1:0]    st;
    logic [CW-1:0] cnt;

    int checks = 0;
    int errors = 0;

    cpu_step_ctrl #(.DEB_CYCLES(DEB), .CNT_W(CW)) dut (
        .CLK_in     (clk),
        .RST_n      (rst_n),
        .slow_clk   (slow),
        .mode_run   (mode),
        .btn_step   (btn),
        .halt_i     (halt),
        .cpu_ce     (ce),
        .state_o    (st),
        .cycle_count(cnt)
    );

    always #5 clk = ~clk;

    // Input history as sampled at each edge, and the model's view.
    logic slow_h [0:HMAX-1];
    logic mode_h [0:HMAX-1];
    logic btn_h  [0:HMAX-1];
    int   k        = 0;
    int   last_rst = 0;
    int   m_st     = 0;
    int   m_cnt    = 0;
    logic m_ce     = 1'b0;
    logic m_deb    = 1'b0;
    logic m_press  = 1'b0;

    // Value of an input as sampled at edge idx; anything at or before the
    // latest reset edge has been wiped out of the synchronisers.
    function automatic logic hv(input int which, input int idx);
        if (idx <= last_rst || idx < 1) return 1'b0;
        case (which)
            0:       return slow_h[idx];
            1:       return mode_h[idx];
            default: return btn_h[idx];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s at step %0d: observed %0h expected %0h", tag, k, got, exp);
        end
    endtask

    task automatic step();
        logic tk;
        logic md;
        logic acc;
        k++;
        slow_h[k] = slow;
        mode_h[k] = mode;
        btn_h[k]  = btn;
        if (!rst_n) begin
            last_rst = k;
            m_st     = 0;
            m_cnt    = 0;
            m_ce     = 1'b0;
            m_deb    = 1'b0;
            m_press  = 1'b0;
        end else begin
            // A rise seen 3 edges ago pulses now; mode is 2 edges stale.
            tk   = hv(0, k - 3) & ~hv(0, k - 4);
            md   = hv(1, k - 2);
            m_ce = 1'b0;
            if (m_st != 2) begin
                if (halt) m_st = 2;
                else if (m_st == 0) begin
                    if (md) m_st = 1;
                    else if (m_press) m_ce = 1'b1;
                end else begin
                    if (!md) m_st = 0;
                    else if (tk) m_ce = 1'b1;
                end
            end
            if (m_ce && m_cnt < CNT_MAX) m_cnt++;
            // Accepted when the synchronised button has disagreed with the
            // accepted level for the last DEB samples.
            acc = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                if (hv(2, k - 2 - j) == m_deb) acc = 1'b0;
            end
            m_press = acc & ~m_deb;
            if (acc) m_deb = ~m_deb;
        end
        @(posedge clk);
        #1;
        chk("cpu_ce", 32'(ce), 32'(m_ce));
        chk("state_o", 32'(st), 32'(m_st));
        chk("cycle_count", 32'(cnt), 32'(m_cnt));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int slow_left;
    int btn_left;

    initial begin
        rst_n = 1'b0;
        slow  = 1'b0;
        mode  = 1'b0;
        btn   = 1'b0;
        halt  = 1'b0;
        #2;

        // Reset with inputs toggling.
        for (int i = 0; i < 5; i++) begin
            slow = $urandom_range(0, 1);
            mode = $urandom_range(0, 1);
            btn  = $urandom_range(0, 1);
            halt = $urandom_range(0, 1);
            step();
            chk("rst_ce", 32'(ce), 32'd0);
            chk("rst_state", 32'(st), 32'd0);
            chk("rst_count", 32'(cnt), 32'd0);
        end
        rst_n = 1'b1;
        slow  = 1'b0;
        mode  = 1'b0;
        btn   = 1'b0;
        halt  = 1'b0;
        steps(10);
        chk("idle_count", 32'(cnt), 32'd0);

        // Free run: slow_clk toggles every 10 cycles for 100 cycles.
        mode = 1'b1;
        for (int i = 0; i < 100; i++) begin
            slow = ((i / 10) % 2) == 1;
            step();
        end
        slow = 1'b0;
        steps(4);
        chk("run_state", 32'(st), 32'd1);
        chk("run_count", 32'(cnt), 32'd5);

        // Single step with a bouncy press.
        mode = 1'b0;
        steps(4);
        chk("pause_state", 32'(st), 32'd0);
        btn = 1'b1; step();
        btn = 1'b0; step();
        btn = 1'b1; step();
        steps(20);
        btn = 1'b0;
        steps(10);
        chk("step_count", 32'(cnt), 32'd6);
        btn = 1'b1;
        steps(2);
        btn = 1'b0;
        steps(10);
        chk("glitch_count", 32'(cnt), 32'd6);

        // Press ignored in RUN.
        mode = 1'b1;
        steps(4);
        btn = 1'b1;
        steps(10);
        btn = 1'b0;
        steps(10);
        chk("run_press_count", 32'(cnt), 32'd6);
        // Ticks ignored in PAUSE.
        mode = 1'b0;
        steps(4);
        for (int i = 0; i < 3; i++) begin
            slow = 1'b1; steps(2);
            slow = 1'b0; steps(2);
        end
        steps(6);
        chk("pause_tick_state", 32'(st), 32'd0);
        chk("pause_tick_count", 32'(cnt), 32'd6);

        // Halt on the same edge a tick is due.
        mode = 1'b1;
        steps(4);
        slow = 1'b1;
        steps(3);
        halt = 1'b1;
        step();
        chk("halt_ce", 32'(ce), 32'd0);
        chk("halt_state", 32'(st), 32'd2);
        halt = 1'b0;
        for (int i = 0; i < 40; i++) begin
            slow = ((i / 3) % 2) == 0;
            btn  = ((i / 10) % 2) == 1;
            mode = ((i / 7) % 2) == 1;
            step();
        end
        chk("halt_hold_state", 32'(st), 32'd2);
        chk("halt_hold_count", 32'(cnt), 32'd6);
        rst_n = 1'b0;
        step();
        chk("halt_rst_state", 32'(st), 32'd0);
        chk("halt_rst_count", 32'(cnt), 32'd0);
        rst_n = 1'b1;
        slow  = 1'b0;
        btn   = 1'b0;

        // Saturation: 17 ticks in RUN, counter stops at 15.
        mode = 1'b1;
        steps(4);
        for (int n = 1; n <= 17; n++) begin
            slow = 1'b1; steps(4);
            slow = 1'b0; steps(4);
            chk("sat_count", 32'(cnt), 32'((n < CNT_MAX) ? n : CNT_MAX));
        end

        // Randomized traffic.
        slow_left = 1;
        btn_left  = 1;
        for (int i = 0; i < 2500; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            halt  = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 59) == 0) mode = ~mode;
            slow_left--;
            if (slow_left == 0) begin
                slow      = ~slow;
                slow_left = $urandom_range(1, 6);
            end
            btn_left--;
            if (btn_left == 0) begin
                btn      = ~btn;
                btn_left = $urandom_range(1, 7);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
